mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-word memory port between icache refill (read-only) and dcache miss
//  traffic (write-back and allocate). Grants one requester at a time and runs a burst of
//  LINE_WORDS beats on the memory port. Forwards read beats to the granted cache and paces
//  write-back data, then signals burst completion. Sits between both caches and main memory.
// PARAMETERS
//  LINE_WORDS  4   words per burst (power of 2, >=2); line base = addr & ~(4*LINE_WORDS-1)
//  ADDR_W      32  byte address width
// PORTS
//  clk       in   1       clock
//  rst       in   1       synchronous, active-high reset
//  ic_req    in   1       icache burst read request; held until ic_done
//  ic_addr   in   ADDR_W  icache miss address (any byte within line)
//  ic_rdata  out  32      read beat data to icache
//  ic_rvalid out  1       ic_rdata valid (one pulse per beat)
//  ic_done   out  1       one-cycle pulse: icache burst complete
//  dc_req    in   1       dcache burst request; held until dc_done
//  dc_we     in   1       1 = write-back burst, 0 = allocate read; held with dc_req
//  dc_addr   in   ADDR_W  dcache line address
//  dc_wdata  in   32      current write-back beat data
//  dc_wnext  out  1       pulse: current write beat accepted; dcache advances dc_wdata
//  dc_rdata  out  32      read beat data to dcache
//  dc_rvalid out  1       dc_rdata valid
//  dc_done   out  1       one-cycle pulse: dcache burst complete
//  mem_req   out  1       memory beat valid
//  mem_we    out  1       beat is write
//  mem_addr  out  ADDR_W  word-aligned beat address
//  mem_wdata out  32      write beat data (= dc_wdata while dcache write granted)
//  mem_ack   in   1       beat transfers on edge where mem_req && mem_ack; read data valid then
//  mem_rdata in   32      read beat data
// BEHAVIOUR
//  - States IDLE, BURST_IC, BURST_DC, DONE. Reset: state=IDLE, last-grant=IC, all outputs 0.
//  - IDLE: requests sampled; one pending -> grant it; both -> grant the one not granted last
//    (after reset dcache wins). Address latched, aligned to line base; beat counter = 0.
//  - BURST_*: mem_req=1 continuously; mem_addr = base + 4*beat (registered). On accepted
//    beat, counter++ and address advances next cycle. No wrap: beats strictly ascending.
//  - Reads: mem_rdata registered; x_rvalid/x_rdata asserted the cycle after accept (1-cycle
//    latency). Non-granted requester's rvalid stays 0.
//  - Writes: mem_wdata combinational from dc_wdata; dc_wnext is combinational
//    mem_req&mem_ack&mem_we. ic path never writes (mem_we=0 in BURST_IC).
//  - Last beat accepted -> DONE: mem_req=0, x_done=1 for exactly that cycle (coincides
//    with final rvalid for reads); then IDLE. Requester drops req during DONE; min one idle
//    cycle between bursts. Back-to-back burst gap = 2 cycles.
//  - mem_ack while mem_req=0: ignored. mem_ack stalls any length: outputs hold.
//  - Requests or dc_we changes during a burst are ignored (req must be held; protocol error
//    otherwise, not checked).
//  - rst mid-burst: at the edge, state->IDLE, mem_req/rvalid/done/wnext drop; burst aborted,
//    no done pulse.
// STRUCTURE
//  - mem_defs.vh: state encodings, requester IDs (REQ_IC=0, REQ_DC=1).
//  - Sub-module rr_arb2: 2-way round-robin picker (req[1:0], last, grant[1:0]), combinational
//    pick + registered last-grant update on grant.
// TESTING
//  - IC read alone: ic_addr=0x1234, mem_ack always 1 -> mem_addr 0x1230,34,38,3C; 4 ic_rvalid
//    with mem_rdata; ic_done with 4th rvalid.
//  - DC write-back: dc_we=1, addr 0x2008 -> beats 0x2000..0x200C, 4 dc_wnext pulses,
//    mem_wdata tracks dc_wdata, dc_done once, no rvalid.
//  - Simultaneous ic_req/dc_req after reset -> DC first, then IC; next tie -> DC again.
//  - mem_ack stalls (ack every 3rd cycle) -> mem_addr/mem_req held, exactly 4 beats, data order
//    preserved.
//  - rst asserted after beat 2 -> next cycle mem_req=0, no done; new ic_req completes full burst.
//  - Continuous dc_req re-asserted after dc_done with ic_req pending -> IC granted (no starvation).

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the cache-to-memory arbiter: FSM state encoding,
//   requester identifiers and the memory data width.
//   No ports (package).
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BURST_IC = 2'd1,
    ST_BURST_DC = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Requester IDs double as bit positions in the 2-bit request/grant vectors.
  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker. The grant is a pure function of the current
//   requests and the last-granted requester; the last-granted record moves
//   only when the owner commits a grant through update_i.
// Ports
//   clk, rst   clock, synchronous active-high reset (last-grant -> IC)
//   req_i      request vector, bit REQ_IC / bit REQ_DC
//   update_i   grant is being taken this cycle; record the winner
//   grant_o    one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  req_id_e last_q;
  req_id_e last_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: the requester not served last time wins.
      2'b11:   grant_o = (last_q == REQ_IC) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (update_i && (grant_o != 2'b00)) begin
      last_d = grant_o[REQ_DC] ? REQ_DC : REQ_IC;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_IC;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares a single-word memory port between icache refills (read-only) and
//   dcache misses (write-back or allocate). One requester is granted at a
//   time; its line is transferred as LINE_WORDS ascending beats, read beats
//   are returned one cycle after acceptance and a one-cycle done pulse closes
//   the burst.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ic_req_i, ic_addr_i       icache burst read request + miss address
//   ic_rdata_o, ic_rvalid_o   icache read beat
//   ic_done_o                 icache burst complete pulse
//   dc_req_i, dc_we_i         dcache burst request, 1 = write-back
//   dc_addr_i, dc_wdata_i     dcache line address, current write beat
//   dc_wnext_o                write beat accepted, dcache advances dc_wdata
//   dc_rdata_o, dc_rvalid_o   dcache read beat
//   dc_done_o                 dcache burst complete pulse
//   mem_req_o, mem_we_o       memory beat valid / beat is a write
//   mem_addr_o, mem_wdata_o   word-aligned beat address / write data
//   mem_ack_i, mem_rdata_i    beat accepted / read data for that beat
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [DATA_W-1:0] ic_rdata_o,
  output logic              ic_rvalid_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              dc_wnext_o,
  output logic [DATA_W-1:0] dc_rdata_o,
  output logic              dc_rvalid_o,
  output logic              dc_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int                BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(4 * LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  state_e              state_q, state_d;
  req_id_e             owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;

  logic [1:0] grant;
  logic       in_burst;
  logic       beat_write;
  logic       accept;
  logic       take_grant;

  // Requests only matter while idle; mid-burst changes are ignored.
  assign take_grant = (state_q == ST_IDLE);
  assign in_burst   = (state_q == ST_BURST_IC) || (state_q == ST_BURST_DC);
  assign beat_write = (state_q == ST_BURST_DC) && we_q;
  // An ack outside a burst is not a transfer.
  assign accept     = in_burst && mem_ack_i;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({dc_req_i, ic_req_i}),
    .update_i (take_grant),
    .grant_o  (grant)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant[REQ_DC])      state_d = ST_BURST_DC;
        else if (grant[REQ_IC]) state_d = ST_BURST_IC;
      end
      ST_BURST_IC,
      ST_BURST_DC: begin
        if (accept && (beat_q == LAST_BEAT)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = in_burst;
    mem_we_o    = beat_write;
    mem_addr_o  = addr_q;
    // Write data passes straight through so the dcache only has to present
    // the current beat; it steps forward when dc_wnext fires.
    mem_wdata_o = beat_write ? dc_wdata_i : '0;
    dc_wnext_o  = accept && beat_write;
    ic_done_o   = (state_q == ST_DONE) && (owner_q == REQ_IC);
    dc_done_o   = (state_q == ST_DONE) && (owner_q == REQ_DC);
    ic_rvalid_o = rvalid_q && (owner_q == REQ_IC);
    dc_rvalid_o = rvalid_q && (owner_q == REQ_DC);
    ic_rdata_o  = rdata_q;
    dc_rdata_o  = rdata_q;
  end

  // ---------------------------------------------------------------------------
  // Burst datapath: owner, direction, beat address/counter, read return.
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    // Read data is returned exactly one cycle after its beat is accepted.
    rvalid_d = accept && !beat_write;

    if (take_grant && (grant != 2'b00)) begin
      owner_d = grant[REQ_DC] ? REQ_DC : REQ_IC;
      // The icache path never writes, whatever dc_we happens to be.
      we_d    = grant[REQ_DC] && dc_we_i;
      addr_d  = (grant[REQ_DC] ? dc_addr_i : ic_addr_i) & ~LINE_MASK;
      beat_d  = '0;
    end else if (accept) begin
      // Beats run strictly upward from the line base; no critical-word wrap.
      addr_d = addr_q + WORD_STEP;
      beat_d = beat_q + 1'b1;
      if (!beat_write) rdata_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= REQ_IC;
      we_q     <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. The bench plays both caches and the
//   memory; a burst-level model predicts beat addresses from the line base and
//   the number of accepted beats, read returns from the data it supplied on
//   accepted beats, and the grant order from a record of who was served last.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic [31:0]   ic_rdata_o;
  logic          ic_rvalid_o;
  logic          ic_done_o;
  logic          dc_req_i = 1'b0;
  logic          dc_we_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [31:0]   dc_wdata_i = '0;
  logic          dc_wnext_o;
  logic [31:0]   dc_rdata_o;
  logic          dc_rvalid_o;
  logic          dc_done_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;

  int vectors     = 0;
  int miscompares = 0;
  bit last_dc     = 1'b0;   // model: was the dcache served most recently

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ic_req_i    (ic_req_i),
    .ic_addr_i   (ic_addr_i),
    .ic_rdata_o  (ic_rdata_o),
    .ic_rvalid_o (ic_rvalid_o),
    .ic_done_o   (ic_done_o),
    .dc_req_i    (dc_req_i),
    .dc_we_i     (dc_we_i),
    .dc_addr_i   (dc_addr_i),
    .dc_wdata_i  (dc_wdata_i),
    .dc_wnext_o  (dc_wnext_o),
    .dc_rdata_o  (dc_rdata_o),
    .dc_rvalid_o (dc_rvalid_o),
    .dc_done_o   (dc_done_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  // Who should win among the currently raised requests (1 = dcache).
  function automatic int winner(input bit ic, input bit dc);
    if (ic && dc) return last_dc ? 0 : 1;
    return dc ? 1 : 0;
  endfunction

  // Follow one burst from grant to done. ack_mode: 0 = always ack, N>0 = ack
  // every Nth burst cycle, -1 = random. exp_wait < 0 skips the gap check.
  // abort_at > 0 resets the DUT once that many beats have transferred.
  task automatic observe_burst(input int who, input bit we, input logic [31:0] addr,
                               input int ack_mode, input int exp_wait, input int abort_at,
                               input bit keep_req, input string tag);
    logic [31:0] base;
    logic [31:0] pend_data;
    logic [31:0] got_rd;
    logic        got_rv, oth_rv;
    int          n, waited, cyc;
    bit          pend, ack, adv;
    base = addr & ~(32'(4 * LW - 1));
    n = 0; waited = 0; cyc = 0; pend = 1'b0; pend_data = '0; adv = 1'b0;

    @(negedge clk);
    while (mem_req_o !== 1'b1) begin
      waited++;
      if (waited > 20) begin
        vectors++; miscompares++;
        $display("FAIL %s start: mem_req got %b required 1 within 20 cycles", tag, mem_req_o);
        if (who == 1) dc_req_i = 1'b0; else ic_req_i = 1'b0;
        return;
      end
      mem_ack_i = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      #1;
      vectors++;
      if (dc_wnext_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle_wnext: got %b required 0", tag, dc_wnext_o);
      end
      @(negedge clk);
    end
    last_dc = (who == 1);
    if (exp_wait >= 0) begin
      vectors++;
      if (waited != exp_wait) begin
        miscompares++;
        $display("FAIL %s gap: idle cycles got %0d required %0d", tag, waited, exp_wait);
      end
    end

    forever begin
      if (adv) begin dc_wdata_i = $urandom; adv = 1'b0; end
      got_rv = (who == 1) ? dc_rvalid_o : ic_rvalid_o;
      oth_rv = (who == 1) ? ic_rvalid_o : dc_rvalid_o;
      got_rd = (who == 1) ? dc_rdata_o  : ic_rdata_o;
      vectors++;
      if (mem_req_o !== 1'b1) begin
        miscompares++;
        $display("FAIL %s mem_req beat %0d: got %b required 1", tag, n, mem_req_o);
      end
      vectors++;
      if (mem_addr_o !== base + 32'(4 * n)) begin
        miscompares++;
        $display("FAIL %s mem_addr beat %0d: got %h required %h", tag, n, mem_addr_o, base + 32'(4 * n));
      end
      vectors++;
      if (mem_we_o !== we) begin
        miscompares++;
        $display("FAIL %s mem_we: got %b required %b", tag, mem_we_o, we);
      end
      vectors++;
      if (got_rv !== pend) begin
        miscompares++;
        $display("FAIL %s rvalid after beat %0d: got %b required %b", tag, n, got_rv, pend);
      end
      if (pend) begin
        vectors++;
        if (got_rd !== pend_data) begin
          miscompares++;
          $display("FAIL %s rdata after beat %0d: got %h required %h", tag, n, got_rd, pend_data);
        end
      end
      vectors++;
      if ({oth_rv, ic_done_o, dc_done_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL %s quiet mid-burst: other_rvalid/ic_done/dc_done got %b required 000",
                 tag, {oth_rv, ic_done_o, dc_done_o});
      end

      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b1; ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ack_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_dc = 1'b0;
        #1;
        vectors++;
        if ({mem_req_o, ic_rvalid_o, dc_rvalid_o, ic_done_o, dc_done_o, dc_wnext_o} !== 6'b0) begin
          miscompares++;
          $display("FAIL %s abort: req/icrv/dcrv/icdone/dcdone/wnext got %b required 000000", tag,
                   {mem_req_o, ic_rvalid_o, dc_rvalid_o, ic_done_o, dc_done_o, dc_wnext_o});
        end
        repeat (3) begin
          @(negedge clk);
          vectors++;
          if ({mem_req_o, ic_done_o, dc_done_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s post_abort: req/icdone/dcdone got %b required 000", tag,
                     {mem_req_o, ic_done_o, dc_done_o});
          end
        end
        return;
      end

      if (ack_mode == 0)     ack = 1'b1;
      else if (ack_mode > 0) ack = ((cyc % ack_mode) == ack_mode - 1);
      else                   ack = 1'($urandom_range(0, 1));
      mem_ack_i = ack;
      mem_rdata_i = $urandom;
      #1;
      vectors++;
      if (dc_wnext_o !== (ack && we)) begin
        miscompares++;
        $display("FAIL %s dc_wnext beat %0d: got %b required %b", tag, n, dc_wnext_o, ack && we);
      end
      if (we) begin
        vectors++;
        if (mem_wdata_o !== dc_wdata_i) begin
          miscompares++;
          $display("FAIL %s mem_wdata beat %0d: got %h required %h", tag, n, mem_wdata_o, dc_wdata_i);
        end
      end
      if (ack) begin
        pend = !we; pend_data = mem_rdata_i; adv = we; n++;
      end else begin
        pend = 1'b0;
      end
      if (n == LW) break;
      cyc++;
      if (cyc > 300) begin
        vectors++; miscompares++;
        $display("FAIL %s timeout: beats got %0d required %0d", tag, n, LW);
        return;
      end
      @(negedge clk);
    end

    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_rdata_i = $urandom;
    got_rv = (who == 1) ? dc_rvalid_o : ic_rvalid_o;
    got_rd = (who == 1) ? dc_rdata_o  : ic_rdata_o;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || dc_wnext_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_cycle req/wnext: got %b%b required 00", tag, mem_req_o, dc_wnext_o);
    end
    vectors++;
    if ({ic_done_o, dc_done_o} !== ((who == 1) ? 2'b01 : 2'b10)) begin
      miscompares++;
      $display("FAIL %s done pulse ic/dc: got %b%b required %b", tag, ic_done_o, dc_done_o,
               (who == 1) ? 2'b01 : 2'b10);
    end
    vectors++;
    if (got_rv !== pend || (pend && got_rd !== pend_data)) begin
      miscompares++;
      $display("FAIL %s final rvalid/rdata: got %b/%h required %b/%h", tag, got_rv, got_rd, pend, pend_data);
    end
    if (!keep_req) begin
      if (who == 1) dc_req_i = 1'b0; else ic_req_i = 1'b0;
    end
  endtask

  task automatic apply_reset();
    ic_req_i = 1'b0; dc_req_i = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_dc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req_o, mem_we_o, ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_done_o, dc_wnext_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset controls: got %b required 0000000",
               {mem_req_o, mem_we_o, ic_rvalid_o, ic_done_o, dc_rvalid_o, dc_done_o, dc_wnext_o});
    end
    vectors++;
    if ({mem_addr_o, mem_wdata_o, ic_rdata_o, dc_rdata_o} !== 128'b0) begin
      miscompares++;
      $display("FAIL reset data: addr %h wdata %h icrd %h dcrd %h required all 0",
               mem_addr_o, mem_wdata_o, ic_rdata_o, dc_rdata_o);
    end
    rst = 1'b0;
    last_dc = 1'b0;
  endtask

  task automatic test_ic_read();
    ic_addr_i = 32'h0000_1234; ic_req_i = 1'b1;
    observe_burst(0, 1'b0, ic_addr_i, 0, -1, 0, 1'b0, "ic_read");
  endtask

  task automatic test_dc_writeback();
    dc_addr_i = 32'h0000_2008; dc_we_i = 1'b1; dc_wdata_i = $urandom; dc_req_i = 1'b1;
    observe_burst(1, 1'b1, dc_addr_i, 0, -1, 0, 1'b0, "dc_writeback");
  endtask

  task automatic test_tie();
    apply_reset();
    ic_addr_i = 32'h0000_3010; dc_addr_i = 32'h0000_4024; dc_we_i = 1'b0;
    ic_req_i = 1'b1; dc_req_i = 1'b1;
    observe_burst(1, 1'b0, dc_addr_i, 0, -1, 0, 1'b0, "tie1_dc");
    observe_burst(0, 1'b0, ic_addr_i, 0, 1, 0, 1'b0, "tie1_ic");
    ic_req_i = 1'b1; dc_req_i = 1'b1;
    observe_burst(1, 1'b0, dc_addr_i, 0, 1, 0, 1'b0, "tie2_dc");
    observe_burst(0, 1'b0, ic_addr_i, 0, 1, 0, 1'b0, "tie2_ic");
  endtask

  task automatic test_stall();
    dc_addr_i = 32'h0000_5004; dc_we_i = 1'b0; dc_req_i = 1'b1;
    observe_burst(1, 1'b0, dc_addr_i, 3, -1, 0, 1'b0, "stall_dc_read");
    dc_addr_i = 32'h0000_5830; dc_we_i = 1'b1; dc_wdata_i = $urandom; dc_req_i = 1'b1;
    observe_burst(1, 1'b1, dc_addr_i, 3, -1, 0, 1'b0, "stall_dc_write");
  endtask

  task automatic test_reset_mid_burst();
    ic_addr_i = 32'h0000_6000; ic_req_i = 1'b1;
    observe_burst(0, 1'b0, ic_addr_i, 0, -1, 2, 1'b0, "abort_ic");
    ic_addr_i = 32'h0000_6044; ic_req_i = 1'b1;
    observe_burst(0, 1'b0, ic_addr_i, 0, -1, 0, 1'b0, "after_abort_ic");
  endtask

  task automatic test_no_starvation();
    apply_reset();
    ic_addr_i = 32'h0000_7000; dc_addr_i = 32'h0000_8000; dc_we_i = 1'b0;
    ic_req_i = 1'b1; dc_req_i = 1'b1;
    observe_burst(1, 1'b0, dc_addr_i, 0, -1, 0, 1'b1, "starve_dc_first");
    observe_burst(0, 1'b0, ic_addr_i, 0, 1, 0, 1'b0, "starve_ic_served");
    observe_burst(1, 1'b0, dc_addr_i, 0, 1, 0, 1'b0, "starve_dc_again");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int  mode, w, ack_mode;
      bit  rq_ic, rq_dc, we;
      mode     = $urandom_range(0, 2);
      rq_ic    = (mode != 1);
      rq_dc    = (mode != 0);
      we       = 1'($urandom_range(0, 1));
      ack_mode = int'($urandom_range(0, 3)) - 1;
      ic_addr_i = $urandom; dc_addr_i = $urandom; dc_we_i = we; dc_wdata_i = $urandom;
      w = winner(rq_ic, rq_dc);
      ic_req_i = rq_ic; dc_req_i = rq_dc;
      if (w == 1) observe_burst(1, we, dc_addr_i, ack_mode, -1, 0, 1'b0, "rand_dc");
      else        observe_burst(0, 1'b0, ic_addr_i, ack_mode, -1, 0, 1'b0, "rand_ic");
      if (rq_ic && rq_dc) begin
        if (w == 1) observe_burst(0, 1'b0, ic_addr_i, ack_mode, 1, 0, 1'b0, "rand_ic_second");
        else        observe_burst(1, we, dc_addr_i, ack_mode, 1, 0, 1'b0, "rand_dc_second");
      end
    end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_writeback();
    test_tie();
    test_stall();
    test_reset_mid_burst();
    test_no_starvation();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_arbiter
